readout_sched: RTL
==================

// Module: readout_sched
// PURPOSE
//  Sequences post-capture readback: fetches N samples from sample memory, strips
//  bytes of disabled channel groups and feeds the byte-wide serial transmitter
//  under its busy handshake. Sits between the capture memory and the output
//  transmitter; kicked off once the capture controller finishes writing.
// PARAMETERS
//  MDW  32  memory data width (4 byte groups; only 32 supported)
//  AW   16  memory address width
// PORTS
//  clk              in   1    core clock
//  rst              in   1    synchronous active-high reset
//  start            in   1    1-cycle pulse: begin readback (ignored while busy)
//  abort            in   1    terminate readback immediately
//  cfg_count        in   AW   number of samples to read, minus 1
//  last_addr        in   AW   address of newest written sample
//  disabled_groups  in   4    bit g=1 -> byte g (data[8g+7:8g]) not sent
//  mem_rd           out  1    1-cycle read request
//  mem_addr         out  AW   read address, valid while mem_rd=1
//  mem_rd_valid     in   1    read data valid (any latency >=1 cycle)
//  mem_rd_data      in   MDW  read data
//  tx_data          out  8    byte to transmit, valid while tx_send=1
//  tx_send          out  1    1-cycle transmit strobe
//  tx_busy          in   1    transmitter busy
//  busy             out  1    readback in progress
//  done             out  1    1-cycle pulse after last byte sent
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, counters 0. Synchronous: takes effect on the
//    clk edge where rst=1, including mid-readback (no done pulse).
//  - FSM: IDLE -> REQ -> WAIT -> SEND -> GAP -> (SEND|NEXT) ; NEXT -> REQ|FIN ; FIN -> IDLE.
//  - IDLE: on start latch cfg_count, last_addr, disabled_groups; set start address;
//    busy=1 from next cycle. Config inputs are not sampled again until next start.
//  - REQ: mem_rd=1 for exactly one cycle with mem_addr; go WAIT.
//  - WAIT: hold until mem_rd_valid=1; latch mem_rd_data; group index g=0.
//    mem_rd_valid outside WAIT is ignored.
//  - SEND: skip groups with disabled_groups[g]=1 (0 cycles each). For first enabled
//    g: wait until tx_busy=0, then tx_send=1 one cycle, tx_data=byte g; go GAP.
//    No enabled group left -> NEXT.
//  - GAP: one mandatory idle cycle (covers transmitter busy-assert latency),
//    g=g+1, back to SEND. Bytes go out in ascending g order.
//  - All four groups disabled: each sample still read, zero bytes sent.
//  - NEXT: samples remaining = 0 -> FIN, else step address, decrement, -> REQ.
//  - FIN: done=1 one cycle, busy=0 same cycle, -> IDLE.
//  - Address arithmetic modulo 2^AW (wraps silently in both directions).
//  - Total samples read = cfg_count+1; cfg_count=0 reads one sample.
//  - abort (any state except IDLE): next cycle FSM=IDLE, busy=0, no done, no further
//    mem_rd/tx_send. abort has priority over every other transition; start
//    coincident with abort in IDLE is honoured (abort ignored in IDLE).
//  - start while busy: ignored, no effect on counters.
// CONFIGURATION
//  READOUT_REVERSE_EN defined: start address = last_addr, decrement per sample
//    (newest sample first, client-side reversal order).
//  Not defined: start address = last_addr - cfg_count, increment per sample
//    (oldest first); final read address is last_addr.
// TESTING
//  1 cfg_count=2, last_addr=0x0010, groups=0000, tx_busy held 0 -> reverse build:
//    addrs 0x10,0x0F,0x0E; 12 tx_send, bytes LSB-first per word; one done.
//  2 groups=1010, data 0xDDCCBBAA -> only 0xAA then 0xCC sent per sample.
//  3 last_addr=0x0001, cfg_count=3, reverse build -> addrs 0x1,0x0,0xFFFF,0xFFFE;
//    forward build -> 0xFFFE,0xFFFF,0x0,0x1.
//  4 tx_busy high 20 cycles after each send, mem_rd_valid latency 5 -> no tx_send
//    while tx_busy=1, no byte lost or duplicated; groups=1111 -> 0 sends, done.
//  5 abort during SEND of sample 2 -> busy=0 next cycle, no done; restart with
//    start completes normally; rst mid-run -> all outputs 0 next edge.

Source files
------------

// File: rtl/readout_if.sv
// Bundles the readback control, memory-read and transmitter handshake signals of readout_sched.
// master: the scheduler side. slave: the capture controller, memory and transmitter side.
interface readout_if #(
  parameter int unsigned AW  = 16,
  parameter int unsigned MDW = 32
);
  logic           start;
  logic           abort;
  logic [AW-1:0]  cfg_count;
  logic [AW-1:0]  last_addr;
  logic [3:0]     disabled_groups;
  logic           mem_rd;
  logic [AW-1:0]  mem_addr;
  logic           mem_rd_valid;
  logic [MDW-1:0] mem_rd_data;
  logic [7:0]     tx_data;
  logic           tx_send;
  logic           tx_busy;
  logic           busy;
  logic           done;

  modport master (
    input  start, abort, cfg_count, last_addr, disabled_groups,
    input  mem_rd_valid, mem_rd_data, tx_busy,
    output mem_rd, mem_addr, tx_data, tx_send, busy, done
  );

  modport slave (
    output start, abort, cfg_count, last_addr, disabled_groups,
    output mem_rd_valid, mem_rd_data, tx_busy,
    input  mem_rd, mem_addr, tx_data, tx_send, busy, done
  );
endinterface

// File: rtl/readout_sched.sv
// Post-capture readback: reads cfg_count+1 samples and streams enabled bytes to the transmitter.
// Define READOUT_REVERSE_EN to read newest sample first (descending addresses).
module readout_sched #(
  parameter int unsigned MDW = 32,
  parameter int unsigned AW  = 16
) (
  input logic       clk,
  input logic       rst,
  readout_if.master bus
);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StSend, StGap, StNext, StFin} state_e;

  state_e         state_q, state_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [AW-1:0]  remain_q, remain_d;
  logic [3:0]     groups_q, groups_d;
  logic [MDW-1:0] data_q, data_d;
  logic [2:0]     grp_q, grp_d;

  logic           found;
  logic [1:0]     sel;
  logic           mem_rd, tx_send, busy, done;
  logic [AW-1:0]  mem_addr;
  logic [7:0]     tx_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      remain_q <= '0;
      groups_q <= '0;
      data_q   <= '0;
      grp_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      groups_q <= groups_d;
      data_q   <= data_d;
      grp_q    <= grp_d;
    end
  end

  // First enabled group at or after the current index; disabled groups cost no cycles.
  always_comb begin
    found = 1'b0;
    sel   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!found && (3'(i) >= grp_q) && !groups_q[i]) begin
        found = 1'b1;
        sel   = 2'(i);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    groups_d = groups_q;
    data_d   = data_q;
    grp_d    = grp_q;
    mem_rd   = 1'b0;
    mem_addr = '0;
    tx_send  = 1'b0;
    tx_data  = '0;
    done     = 1'b0;
    busy     = (state_q != StIdle) && (state_q != StFin);

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
`ifdef READOUT_REVERSE_EN
          addr_d = bus.last_addr;
`else
          addr_d = bus.last_addr - bus.cfg_count;
`endif
          remain_d = bus.cfg_count;
          groups_d = bus.disabled_groups;
          state_d  = StReq;
        end
      end
      StReq: begin
        mem_rd   = 1'b1;
        mem_addr = addr_q;
        state_d  = StWait;
      end
      StWait: begin
        if (bus.mem_rd_valid) begin
          data_d  = bus.mem_rd_data;
          grp_d   = '0;
          state_d = StSend;
        end
      end
      StSend: begin
        if (found) begin
          grp_d = {1'b0, sel};
          if (!bus.tx_busy) begin
            tx_send = 1'b1;
            tx_data = data_q[{sel, 3'b000} +: 8];
            state_d = StGap;
          end
        end else begin
          state_d = StNext;
        end
      end
      StGap: begin
        grp_d   = grp_q + 3'd1;
        state_d = StSend;
      end
      StNext: begin
        if (remain_q == '0) begin
          state_d = StFin;
        end else begin
`ifdef READOUT_REVERSE_EN
          addr_d = addr_q - AW'(1);
`else
          addr_d = addr_q + AW'(1);
`endif
          remain_d = remain_q - AW'(1);
          state_d  = StReq;
        end
      end
      StFin: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Abort wins over everything and also silences this cycle's strobes.
    if (bus.abort && (state_q != StIdle)) begin
      state_d  = StIdle;
      mem_rd   = 1'b0;
      mem_addr = '0;
      tx_send  = 1'b0;
      tx_data  = '0;
      done     = 1'b0;
    end
  end

  assign bus.mem_rd   = mem_rd;
  assign bus.mem_addr = mem_addr;
  assign bus.tx_send  = tx_send;
  assign bus.tx_data  = tx_data;
  assign bus.busy     = busy;
  assign bus.done     = done;

endmodule
